// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler that feeds three byte requesters into a memory-mapped UART
// TX data register, polls the status register for completion and aborts on timeout.
`timescale 1ns/1ps
module uart_tx_scheduler #(
    parameter int unsigned POLL_TIMEOUT = 200000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  req_valid,
    input  logic [23:0] req_data,
    output logic [2:0]  req_ready,
    output logic [2:0]  tx_done,
    output logic        busy,
    output logic        err,
    output logic        rd,
    output logic        wr,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    input  logic [31:0] rdata
);

    // state | meaning
    // INIT  | one read of the TX data register to drop a stale done flag
    // IDLE  | arbitrate; accept the round-robin winner's byte
    // WRITE | write latched byte to the TX data register
    // POLL  | read status until bit 2 (TX done) or timeout
    // CLEAR | read TX data register to acknowledge the done flag
    // DONE  | pulse tx_done to the owning requester
    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_WRITE,
        S_POLL,
        S_CLEAR,
        S_DONE
    } state_t;

    localparam logic [31:0] ADDR_TXDATA = 32'h4000_0018;
    localparam logic [31:0] ADDR_STATUS = 32'h4000_0020;
    localparam logic [19:0] POLL_LIMIT  = 20'(POLL_TIMEOUT);

    state_t      r_state;
    logic [1:0]  r_last_grant;
    logic [1:0]  r_owner;
    logic [7:0]  r_byte;
    logic [19:0] r_poll_cnt;
    logic        r_err;

    logic        w_any;
    logic [1:0]  w_win;
    logic [7:0]  w_win_byte;
    logic [19:0] w_poll_next;
    logic        w_unused_rdata;

    assign w_any          = |req_valid;
    assign w_poll_next    = r_poll_cnt + 20'd1;
    assign w_unused_rdata = ^{rdata[31:3], rdata[1:0]};

    // Search starts one past the last grant and wraps modulo 3.
    always_comb begin
        w_win = 2'd0;
        case (r_last_grant)
            2'd0:    w_win = req_valid[1] ? 2'd1 : (req_valid[2] ? 2'd2 : 2'd0);
            2'd1:    w_win = req_valid[2] ? 2'd2 : (req_valid[0] ? 2'd0 : 2'd1);
            default: w_win = req_valid[0] ? 2'd0 : (req_valid[1] ? 2'd1 : 2'd2);
        endcase
    end

    always_comb begin
        w_win_byte = req_data[7:0];
        case (w_win)
            2'd1:    w_win_byte = req_data[15:8];
            2'd2:    w_win_byte = req_data[23:16];
            default: w_win_byte = req_data[7:0];
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_INIT;
            r_last_grant <= 2'd2;
            r_owner      <= 2'd0;
            r_byte       <= 8'd0;
            r_poll_cnt   <= 20'd0;
            r_err        <= 1'b0;
        end else begin
            unique case (r_state)
                S_INIT: r_state <= S_IDLE;
                S_IDLE: begin
                    if (w_any) begin
                        r_byte       <= w_win_byte;
                        r_owner      <= w_win;
                        r_last_grant <= w_win;
                        r_state      <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    r_poll_cnt <= 20'd0;
                    r_state    <= S_POLL;
                end
                S_POLL: begin
                    // Completion seen on the final allowed poll still wins over timeout.
                    if (rdata[2]) begin
                        r_state <= S_CLEAR;
                    end else if (w_poll_next >= POLL_LIMIT) begin
                        r_err   <= 1'b1;
                        r_state <= S_INIT;
                    end else begin
                        r_poll_cnt <= w_poll_next;
                    end
                end
                S_CLEAR: r_state <= S_DONE;
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_INIT;
            endcase
        end
    end

    // Outputs decode the state register and are gated by reset, so INIT's read is
    // visible in the first cycle after release while everything reads 0 during reset.
    always_comb begin
        rd        = 1'b0;
        wr        = 1'b0;
        addr      = 32'd0;
        wdata     = 32'd0;
        tx_done   = 3'd0;
        req_ready = 3'd0;
        if (reset) begin
            case (r_state)
                S_INIT: begin
                    rd   = 1'b1;
                    addr = ADDR_TXDATA;
                end
                S_IDLE: begin
                    if (w_any) req_ready = 3'b001 << w_win;
                end
                S_WRITE: begin
                    wr    = 1'b1;
                    addr  = ADDR_TXDATA;
                    wdata = {24'd0, r_byte};
                end
                S_POLL: begin
                    rd   = 1'b1;
                    addr = ADDR_STATUS;
                end
                S_CLEAR: begin
                    rd   = 1'b1;
                    addr = ADDR_TXDATA;
                end
                S_DONE:  tx_done = 3'b001 << r_owner;
                default: ;
            endcase
        end
    end

    assign busy = reset && (r_state != S_IDLE);
    assign err  = r_err;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a status-register bus model that
// reports TX done on a chosen poll number.
`timescale 1ns/1ps
module tb_uart_tx_scheduler;

    localparam logic [31:0] A_TX = 32'h4000_0018;
    localparam logic [31:0] A_ST = 32'h4000_0020;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  req_valid = 3'd0;
    logic [23:0] req_data = 24'd0;
    logic [2:0]  req_ready;
    logic [2:0]  tx_done;
    logic        busy;
    logic        err;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    int n_tests = 0;
    int n_fail  = 0;
    int poll_total = 0;
    int done_target = 0;

    logic [69:0] obs;
    assign obs = {rd, wr, addr, wdata, tx_done, busy};

    uart_tx_scheduler #(.POLL_TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx_done(tx_done), .busy(busy), .err(err),
        .rd(rd), .wr(wr), .addr(addr), .wdata(wdata), .rdata(rdata)
    );

    always #5 clk = ~clk;

    // Status bit 2 goes high on the poll whose running number equals done_target.
    assign rdata = (rd && addr == A_ST && (poll_total + 1 == done_target)) ? 32'h4 : 32'h0;
    always @(posedge clk) if (rd && addr == A_ST) poll_total <= poll_total + 1;

    function automatic logic [69:0] exp_vec(logic e_rd, logic e_wr, logic [31:0] e_addr,
                                            logic [31:0] e_wdata, logic [2:0] e_done, logic e_busy);
        return {e_rd, e_wr, e_addr, e_wdata, e_done, e_busy};
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_tests++;
        if ({obs, req_ready, err} !== 74'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %h required 0", {obs, req_ready, err});
        end
        @(negedge clk); reset = 1'b1; #1;
        n_tests++;
        if (obs !== exp_vec(1, 0, A_TX, 0, 0, 1) || err !== 1'b0) begin
            n_fail++; $display("FAIL reset_init_cycle: got %h err %b required %h err 0", obs, err, exp_vec(1, 0, A_TX, 0, 0, 1));
        end
        @(negedge clk); #1;
        n_tests++;
        if (obs !== exp_vec(0, 0, 0, 0, 0, 0)) begin
            n_fail++; $display("FAIL reset_idle: got %h required %h", obs, exp_vec(0, 0, 0, 0, 0, 0));
        end
    endtask

    task automatic test_single();
        logic [69:0] e;
        @(negedge clk);
        req_data = 24'hCC_BB_55; req_valid = 3'b001; done_target = poll_total + 5; #1;
        n_tests++;
        if (req_ready !== 3'b001 || busy !== 1'b0) begin
            n_fail++; $display("FAIL single_accept: got ready %b busy %b required 001 0", req_ready, busy);
        end
        @(negedge clk); req_valid = 3'b000; #1;
        n_tests++;
        if (obs !== exp_vec(0, 1, A_TX, 32'h55, 0, 1) || req_ready !== 3'b000) begin
            n_fail++; $display("FAIL single_write: got %h ready %b required %h", obs, req_ready, exp_vec(0, 1, A_TX, 32'h55, 0, 1));
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); #1;
            if (k < 5)       e = exp_vec(1, 0, A_ST, 0, 0, 1);
            else if (k == 5) e = exp_vec(1, 0, A_TX, 0, 0, 1);
            else if (k == 6) e = exp_vec(0, 0, 0, 0, 3'b001, 1);
            else             e = exp_vec(0, 0, 0, 0, 0, 0);
            n_tests++;
            if (obs !== e) begin
                n_fail++; $display("FAIL single_seq_%0d: got %h required %h", k, obs, e);
            end
        end
    endtask

    task automatic test_contention();
        logic [7:0] bytes [3];
        int e;
        bytes[0] = 8'hA0; bytes[1] = 8'hB1; bytes[2] = 8'hC2;
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        req_data = 24'hC2_B1_A0;
        for (int g = 0; g < 4; g++) begin
            e = g % 3;
            @(negedge clk); req_valid = 3'b111; done_target = poll_total + 1; #1;
            n_tests++;
            if (req_ready !== (3'b001 << e)) begin
                n_fail++; $display("FAIL contention_grant_%0d: got %b required %b", g, req_ready, 3'b001 << e);
            end
            @(negedge clk); #1;
            n_tests++;
            if (obs !== exp_vec(0, 1, A_TX, {24'd0, bytes[e]}, 0, 1)) begin
                n_fail++; $display("FAIL contention_wdata_%0d: got %h required %h", g, obs, exp_vec(0, 1, A_TX, {24'd0, bytes[e]}, 0, 1));
            end
            repeat (2) @(negedge clk);
            @(negedge clk); #1;
            n_tests++;
            if (tx_done !== (3'b001 << e) || rd !== 1'b0) begin
                n_fail++; $display("FAIL contention_done_%0d: got %b required %b", g, tx_done, 3'b001 << e);
            end
        end
        @(negedge clk); req_valid = 3'b000; #1;
        n_tests++;
        if (req_ready !== 3'b000 || busy !== 1'b0) begin
            n_fail++; $display("FAIL contention_idle: got ready %b busy %b required 000 0", req_ready, busy);
        end
    endtask

    task automatic test_timeout();
        @(negedge clk); req_valid = 3'b100; req_data = 24'h7E_00_00; done_target = 0; #1;
        n_tests++;
        if (req_ready !== 3'b100) begin
            n_fail++; $display("FAIL timeout_accept: got %b required 100", req_ready);
        end
        @(negedge clk); req_valid = 3'b000; #1;
        n_tests++;
        if (obs !== exp_vec(0, 1, A_TX, 32'h7E, 0, 1)) begin
            n_fail++; $display("FAIL timeout_write: got %h required %h", obs, exp_vec(0, 1, A_TX, 32'h7E, 0, 1));
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); #1;
            n_tests++;
            if (obs !== exp_vec(1, 0, A_ST, 0, 0, 1) || err !== 1'b0) begin
                n_fail++; $display("FAIL timeout_poll_%0d: got %h err %b required %h err 0", k, obs, err, exp_vec(1, 0, A_ST, 0, 0, 1));
            end
        end
        @(negedge clk); #1;
        n_tests++;
        if (obs !== exp_vec(1, 0, A_TX, 0, 0, 1) || err !== 1'b1) begin
            n_fail++; $display("FAIL timeout_init: got %h err %b required %h err 1", obs, err, exp_vec(1, 0, A_TX, 0, 0, 1));
        end
        @(negedge clk); #1;
        n_tests++;
        if (obs !== exp_vec(0, 0, 0, 0, 0, 0) || err !== 1'b1) begin
            n_fail++; $display("FAIL timeout_idle: got %h err %b required 0 err 1", obs, err);
        end
        repeat (3) @(negedge clk);
        #1;
        n_tests++;
        if (err !== 1'b1) begin
            n_fail++; $display("FAIL timeout_err_sticky: got %b required 1", err);
        end
    endtask

    task automatic test_busy_arrival();
        @(negedge clk); req_valid = 3'b001; req_data = 24'h00_66_11; done_target = poll_total + 3; #1;
        n_tests++;
        if (req_ready !== 3'b001) begin
            n_fail++; $display("FAIL arrival_first_accept: got %b required 001", req_ready);
        end
        @(negedge clk); req_valid = 3'b000;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0) req_valid = 3'b010;
            #1;
            n_tests++;
            if (req_ready !== 3'b000 || tx_done !== ((k == 4) ? 3'b001 : 3'b000)) begin
                n_fail++; $display("FAIL arrival_held_%0d: got ready %b done %b required 000 %b", k, req_ready, tx_done, (k == 4) ? 3'b001 : 3'b000);
            end
        end
        @(negedge clk); done_target = poll_total + 1; #1;
        n_tests++;
        if (req_ready !== 3'b010 || busy !== 1'b0) begin
            n_fail++; $display("FAIL arrival_grant: got ready %b busy %b required 010 0", req_ready, busy);
        end
        @(negedge clk); req_valid = 3'b000; #1;
        n_tests++;
        if (obs !== exp_vec(0, 1, A_TX, 32'h66, 0, 1)) begin
            n_fail++; $display("FAIL arrival_write: got %h required %h", obs, exp_vec(0, 1, A_TX, 32'h66, 0, 1));
        end
        repeat (2) @(negedge clk);
        @(negedge clk); #1;
        n_tests++;
        if (tx_done !== 3'b010) begin
            n_fail++; $display("FAIL arrival_done: got %b required 010", tx_done);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_poll();
        @(negedge clk); req_valid = 3'b001; req_data = 24'h00_00_99; done_target = 0; #1;
        n_tests++;
        if (req_ready !== 3'b001) begin
            n_fail++; $display("FAIL midrst_accept: got %b required 001", req_ready);
        end
        @(negedge clk); req_valid = 3'b000;
        @(negedge clk); #1;
        n_tests++;
        if (obs !== exp_vec(1, 0, A_ST, 0, 0, 1)) begin
            n_fail++; $display("FAIL midrst_poll: got %h required %h", obs, exp_vec(1, 0, A_ST, 0, 0, 1));
        end
        @(negedge clk); reset = 1'b0; #1;
        n_tests++;
        if ({obs, req_ready, err} !== 74'd0) begin
            n_fail++; $display("FAIL midrst_outputs: got %h required 0", {obs, req_ready, err});
        end
        @(negedge clk);
        @(negedge clk); reset = 1'b1; #1;
        n_tests++;
        if (obs !== exp_vec(1, 0, A_TX, 0, 0, 1)) begin
            n_fail++; $display("FAIL midrst_init: got %h required %h", obs, exp_vec(1, 0, A_TX, 0, 0, 1));
        end
        @(negedge clk); req_valid = 3'b110; req_data = 24'h00_44_00; done_target = poll_total + 1; #1;
        n_tests++;
        if (req_ready !== 3'b010 || busy !== 1'b0 || tx_done !== 3'b000) begin
            n_fail++; $display("FAIL midrst_priority: got ready %b busy %b done %b required 010 0 000", req_ready, busy, tx_done);
        end
        @(negedge clk); req_valid = 3'b000;
        repeat (2) @(negedge clk);
        @(negedge clk); #1;
        n_tests++;
        if (tx_done !== 3'b010) begin
            n_fail++; $display("FAIL midrst_done: got %b required 010", tx_done);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_timeout();
        test_busy_arrival();
        test_reset_mid_poll();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 SHALL have parameter POLL_TIMEOUT, default 200000, the maximum number of POLL cycles per byte before abort (legal range 1..2^20-1).
REQ-002 SHALL have port clk  input  1  system clock; all state changes on the rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req_valid  input  3  per-requester byte-pending flag; bit i belongs to requester i.
REQ-005 SHALL have port req_data  input  24  requester i's byte on bits [8i+7:8i].
REQ-006 SHALL have port req_ready  output  3  one-hot accept strobe; a byte transfers when req_valid[i] and req_ready[i] are both high.
REQ-007 SHALL have port tx_done  output  3  one-cycle pulse to the owning requester when its byte has finished transmitting.
REQ-008 SHALL have port busy  output  1  high in every state except IDLE.
REQ-009 SHALL have port err  output  1  sticky timeout flag.
REQ-010 SHALL have port rd  output  1  peripheral bus read strobe.
REQ-011 SHALL have port wr  output  1  peripheral bus write strobe.
REQ-012 SHALL have port addr  output  32  peripheral bus address.
REQ-013 SHALL have port wdata  output  32  peripheral bus write data.
REQ-014 SHALL have port rdata  input  32  peripheral bus read data, combinationally valid in the same cycle that rd is high.

Function
REQ-015 SHALL implement the states INIT, IDLE, WRITE, POLL, CLEAR and DONE.
REQ-016 INIT SHALL last 1 cycle and drive rd=1 with addr=0x40000018 to clear any stale TX-done flag, then go to IDLE.
REQ-017 In IDLE, when any req_valid bit is high, the block SHALL select a winner round-robin: search from (last_grant+1) mod 3 upward and take the first valid requester.
REQ-018 In IDLE, the block SHALL assert req_ready[winner] combinationally in that cycle, latch that requester's byte and index, set last_grant to the winner, and go to WRITE.
REQ-019 In IDLE with no valid requester, req_ready SHALL be 0 and the block SHALL stay in IDLE.
REQ-020 WRITE SHALL last 1 cycle, drive wr=1, addr=0x40000018 and wdata={24'b0,byte}, then go to POLL.
REQ-021 Each POLL cycle SHALL drive rd=1 with addr=0x40000020.
REQ-022 If rdata[2]=1 during a POLL cycle, the block SHALL go to CLEAR.
REQ-023 The POLL cycle counter SHALL count from 1; if it reaches POLL_TIMEOUT with rdata[2]=0, the block SHALL set err=1 and go to INIT, and SHALL NOT pulse tx_done.
REQ-024 CLEAR SHALL last 1 cycle, drive rd=1 with addr=0x40000018, then go to DONE.
REQ-025 DONE SHALL last 1 cycle, pulse tx_done[owner] for exactly that cycle, then go to IDLE.
REQ-026 In any cycle where the state drives no bus access, rd, wr, addr and wdata SHALL all be 0.
REQ-027 At most one of rd and wr SHALL be high in any cycle.
REQ-028 req_ready SHALL be 0 outside IDLE; requests arriving while busy are held by their requester and are not lost.
REQ-029 Minimum issue spacing: accept at cycle T -> WRITE at T+1 -> first POLL at T+2; next accept no earlier than 3 cycles after the first POLL cycle that sees rdata[2]=1.
REQ-030 Fairness: a requester holding req_valid continuously SHALL be granted within 3 grants.
REQ-031 err SHALL clear only on reset.
REQ-032 The POLL counter SHALL be 20 bits wide, reset to 0 on entry to POLL, and never wrap.

Reset
REQ-033 While reset=0, the block SHALL force state=INIT, last_grant=2 (so requester 0 has first priority), req_ready=0, tx_done=0, err=0, rd=0, wr=0, addr=0, wdata=0, and clear the byte latch and POLL counter.
REQ-034 An assertion of reset mid-transfer SHALL abandon the transfer with no tx_done pulse.
REQ-035 After reset deasserts, the first active cycle SHALL be INIT, so busy=1 in that cycle.

Verification
REQ-036 Single request: req_valid=001, req_data[7:0]=0x55; the bus model sets rdata[2]=1 on the 5th POLL -> wr at 0x40000018 with wdata=0x55 one cycle after accept, exactly 5 rd cycles to 0x40000020, 1 rd to 0x40000018, then tx_done=001 for 1 cycle.
REQ-037 Contention: req_valid=111 held throughout -> grant order 0,1,2,0, each with its own byte on wdata.
REQ-038 Timeout: POLL_TIMEOUT=8 and rdata[2] held at 0 -> exactly 8 POLL cycles, err=1, no tx_done, then INIT, then IDLE; err stays 1 thereafter.
REQ-039 Reset mid-POLL: reset=0 during POLL -> all outputs 0 in the same cycle; after release, one INIT read of 0x40000018, then IDLE.
REQ-040 Arrival while busy: req_valid[1] rises during POLL of requester 0 -> req_ready stays 0 until IDLE, then req_ready=010 in the first IDLE cycle.
